// File: rtl/sd_data_rx.sv
// sd_data_rx: SD-card DAT-line block receiver.
// Samples BUS_W (1 or 4) DAT lines once per clk and waits for an all-zero
// start bit. It then assembles bytes and checks each line's CRC16 and the
// end bit. Bytes go out on a valid/ready stream through a small FIFO.
// Ports:
//   clk, rst                  - sample clock, async active-high reset
//   i_start / i_abort         - transfer request (rising edge) / abort (level)
//   i_blk_len / i_blk_cnt     - bytes per block / blocks per transfer (0 -> 1)
//   i_sd_data                 - DAT lines, bit n = DATn
//   o_st_data/vld/sop/eop     - output byte stream, i_st_rdy back-pressure
//   o_busy, o_done            - activity level, end-of-transfer pulse
//   o_status                  - {overrun, timeout, abort, endbit_err, crc_err[3:0]}
module sd_data_rx #(
  parameter int BUS_W      = 4,
  parameter int LEN_W      = 10,
  parameter int TIMEOUT    = 5000,
  parameter int TO_W       = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [LEN_W-1:0] i_blk_len,
  input  logic [15:0]      i_blk_cnt,
  input  logic [BUS_W-1:0] i_sd_data,
  output logic [7:0]       o_st_data,
  output logic             o_st_vld,
  input  logic             i_st_rdy,
  output logic             o_st_sop,
  output logic             o_st_eop,
  output logic             o_busy,
  output logic             o_done,
  output logic [7:0]       o_status
);
  localparam int BPB = 8 / BUS_W;  // bus beats per byte
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, WAIT_START, DATA, CRC, END_BIT} state_t;
  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } beat_t;

  state_t           state;
  logic             start_q, sop_due, in_pkt, done;
  logic [LEN_W-1:0] len_q, byte_cnt;
  logic [15:0]      blk_rem;
  logic [TO_W-1:0]  to_cnt;
  logic [2:0]       bit_cnt;
  logic [3:0]       crc_cnt;
  logic [7-BUS_W:0] shreg;
  logic [7:0]       status;

  logic       start_edge, start_bit, byte_end, last_byte, last_blk;
  logic       abort_now, to_now, crc_clr;
  logic [7:0] byte_now;
  logic [3:0] crc_err;

  assign start_edge = i_start && !start_q;
  assign start_bit  = (i_sd_data == '0);
  assign byte_end   = (state == DATA) && (bit_cnt == 3'(BPB - 1));
  assign last_byte  = (byte_cnt == len_q - LEN_W'(1));
  assign last_blk   = (blk_rem == 16'd1);
  assign abort_now  = i_abort && (state != IDLE);
  assign to_now     = (state == WAIT_START) && !start_bit && !abort_now &&
                      (to_cnt == TO_W'(TIMEOUT - 1));
  // Byte as it stands including the bits on the bus this cycle, so a byte
  // is pushed on the same cycle its last bit is sampled.
  assign byte_now   = {shreg, i_sd_data};
  assign crc_clr    = ((state == IDLE) && start_edge) ||
                      ((state == WAIT_START) && start_bit);

  // Per-line CRC16-CCITT over data bits, plus the received CRC shifted in.
  for (genvar n = 0; n < 4; n++) begin : g_lane
    if (n < BUS_W) begin : g_on
      logic [15:0] calc, rx;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          calc <= '0;
          rx   <= '0;
        end else if (crc_clr) begin
          calc <= '0;
          rx   <= '0;
        end else begin
          if (state == DATA)
            calc <= {calc[14:0], 1'b0} ^ ((calc[15] ^ i_sd_data[n]) ? 16'h1021 : 16'h0000);
          if (state == CRC)
            rx <= {rx[14:0], i_sd_data[n]};
        end
      end
      assign crc_err[n] = (calc != rx);
    end else begin : g_off
      assign crc_err[n] = 1'b0;
    end
  end

  // Push selection: an abort/timeout inside an open packet closes it with a
  // zero filler beat instead of the data byte.
  beat_t push_beat;
  logic  push, pop, full, accept, ovf;

  always_comb begin
    push      = 1'b0;
    push_beat = '0;
    if ((abort_now || to_now) && in_pkt) begin
      push          = 1'b1;
      push_beat.eop = 1'b1;
    end else if (byte_end && !abort_now) begin
      push           = 1'b1;
      push_beat.sop  = sop_due;
      push_beat.eop  = last_byte && last_blk;
      push_beat.data = byte_now;
    end
  end

  // Output FIFO
  beat_t         mem [FIFO_DEPTH];
  beat_t         head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  assign full   = (count == (AW+1)'(FIFO_DEPTH));
  assign pop    = o_st_vld && i_st_rdy;
  assign accept = push && (!full || pop);
  assign ovf    = push && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= push_beat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};
    end
  end

  assign head      = mem[rd_ptr];
  assign o_st_vld  = (count != '0);
  assign o_st_data = o_st_vld ? head.data : 8'h00;
  assign o_st_sop  = o_st_vld && head.sop;
  assign o_st_eop  = o_st_vld && head.eop;
  assign o_busy    = (state != IDLE) || o_st_vld;
  assign o_done    = done;
  assign o_status  = status;

  // Control FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      start_q  <= 1'b0;
      sop_due  <= 1'b0;
      in_pkt   <= 1'b0;
      done     <= 1'b0;
      len_q    <= '0;
      byte_cnt <= '0;
      blk_rem  <= '0;
      to_cnt   <= '0;
      bit_cnt  <= '0;
      crc_cnt  <= '0;
      shreg    <= '0;
      status   <= '0;
    end else begin
      start_q <= i_start;
      done    <= 1'b0;
      if (ovf) status[7] <= 1'b1;
      case (state)
        IDLE: if (start_edge) begin
          state    <= WAIT_START;
          len_q    <= (i_blk_len == '0) ? LEN_W'(1) : i_blk_len;
          blk_rem  <= (i_blk_cnt == '0) ? 16'd1 : i_blk_cnt;
          status   <= '0;
          to_cnt   <= '0;
          byte_cnt <= '0;
          bit_cnt  <= '0;
          sop_due  <= 1'b1;
          in_pkt   <= 1'b0;
        end
        WAIT_START: begin
          if (start_bit) begin
            state    <= DATA;
            to_cnt   <= '0;
            byte_cnt <= '0;
            bit_cnt  <= '0;
          end else if (to_now) begin
            status[6] <= 1'b1;
            state     <= IDLE;
            done      <= 1'b1;
            in_pkt    <= 1'b0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        DATA: begin
          shreg <= byte_now[7-BUS_W:0];
          if (byte_end) begin
            bit_cnt <= '0;
            sop_due <= 1'b0;
            in_pkt  <= !(last_byte && last_blk);
            if (last_byte) begin
              state   <= CRC;
              crc_cnt <= '0;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        CRC: begin
          crc_cnt <= crc_cnt + 1'b1;
          if (crc_cnt == 4'd15) state <= END_BIT;
        end
        END_BIT: begin
          if (i_sd_data != '1) status[4] <= 1'b1;
          status[3:0] <= status[3:0] | crc_err;
          if (last_blk) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            blk_rem <= blk_rem - 16'd1;
            state   <= WAIT_START;
            to_cnt  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
      // Abort wins over whatever the state was doing this cycle.
      if (abort_now) begin
        state     <= IDLE;
        status[5] <= 1'b1;
        done      <= 1'b1;
        in_pkt    <= 1'b0;
        sop_due   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sd_data_rx.sv
// Bench for sd_data_rx: a 4-line instance and a 1-line instance.
// Expected stream beats are queued when stimulus is issued; a monitor per
// instance pops and compares every accepted beat.
module tb_sd_data_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } beat_t;

  beat_t q4[$];
  beat_t q1[$];
  logic [7:0] blk_bytes [16];

  // 4-line instance
  logic       start4 = 0, abort4 = 0, rdy4 = 1;
  logic [9:0] len4 = 0;
  logic [15:0] cnt4 = 0;
  logic [3:0] sd4 = 4'hF;
  logic [7:0] data4, status4;
  logic       vld4, sop4, eop4, busy4, done4;

  // 1-line instance
  logic       start1 = 0, abort1 = 0, rdy1 = 1;
  logic [9:0] len1 = 0;
  logic [15:0] cnt1 = 0;
  logic [0:0] sd1 = 1'b1;
  logic [7:0] data1, status1;
  logic       vld1, sop1, eop1, busy1, done1;

  sd_data_rx #(.BUS_W(4), .TIMEOUT(20), .FIFO_DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .i_start(start4), .i_abort(abort4),
    .i_blk_len(len4), .i_blk_cnt(cnt4), .i_sd_data(sd4),
    .o_st_data(data4), .o_st_vld(vld4), .i_st_rdy(rdy4),
    .o_st_sop(sop4), .o_st_eop(eop4), .o_busy(busy4),
    .o_done(done4), .o_status(status4));

  sd_data_rx #(.BUS_W(1), .TIMEOUT(20), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .i_start(start1), .i_abort(abort1),
    .i_blk_len(len1), .i_blk_cnt(cnt1), .i_sd_data(sd1),
    .o_st_data(data1), .o_st_vld(vld1), .i_st_rdy(rdy1),
    .o_st_sop(sop1), .o_st_eop(eop1), .o_busy(busy1),
    .o_done(done1), .o_status(status1));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  task automatic exp4(input logic [7:0] d, input logic sop, input logic eop);
    q4.push_back({sop, eop, d});
  endtask

  // Monitors: sampled mid-low-phase, away from both clock edges.
  int done_n4 = 0, last_done4 = -1;
  int done_n1 = 0, last_done1 = -1;
  always begin
    beat_t e;
    @(negedge clk); #3;
    if (!rst) begin
      if (vld4 && rdy4) begin
        if (q4.size() == 0) begin
          checks++; failures++;
          $display("FAIL beat4_extra: got data=0x%0h sop=%0d eop=%0d, none expected", data4, sop4, eop4);
        end else begin
          e = q4.pop_front();
          chk("beat4", int'({sop4, eop4, data4}), int'(e));
        end
      end
      if (done4) begin done_n4++; last_done4 = cyc + 1; end
    end
  end
  always begin
    beat_t e;
    @(negedge clk); #3;
    if (!rst) begin
      if (vld1 && rdy1) begin
        if (q1.size() == 0) begin
          checks++; failures++;
          $display("FAIL beat1_extra: got data=0x%0h sop=%0d eop=%0d, none expected", data1, sop1, eop1);
        end else begin
          e = q1.pop_front();
          chk("beat1", int'({sop1, eop1, data1}), int'(e));
        end
      end
      if (done1) begin done_n1++; last_done1 = cyc + 1; end
    end
  end

  // Cycle numbering: a value driven at a negedge is sampled at cycle cyc+1.
  task automatic start_x4(input int len, input int cnt, output int t);
    @(negedge clk); len4 = 10'(len); cnt4 = 16'(cnt); start4 = 1'b1; t = cyc + 1;
    @(negedge clk); start4 = 1'b0;
  endtask

  task automatic start_x1(input int len, input int cnt, output int t);
    @(negedge clk); len1 = 10'(len); cnt1 = 16'(cnt); start1 = 1'b1; t = cyc + 1;
    @(negedge clk); start1 = 1'b0;
  endtask

  // One 4-line block: start bit, nsend bytes, and (if complete) CRC + end bit.
  task automatic block4(input int base, input int len, input int nsend,
                        input int flip_lane, input bit bad_end0, output int s);
    logic [15:0] crc [4];
    logic [3:0]  nib;
    for (int n = 0; n < 4; n++) crc[n] = '0;
    @(negedge clk); sd4 = 4'h0; s = cyc + 1;
    for (int k = 0; k < nsend; k++) begin
      for (int h = 0; h < 2; h++) begin
        nib = (h == 0) ? blk_bytes[base+k][7:4] : blk_bytes[base+k][3:0];
        @(negedge clk); sd4 = nib;
        for (int n = 0; n < 4; n++) crc[n] = crc_step(crc[n], nib[n]);
      end
    end
    if (nsend < len) return;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      for (int n = 0; n < 4; n++) sd4[n] = crc[n][15-i] ^ ((n == flip_lane) && (i == 5));
    end
    @(negedge clk); sd4 = bad_end0 ? 4'hE : 4'hF;
    @(negedge clk); sd4 = 4'hF;
  endtask

  task automatic block1(input int base, input int len, output int s);
    logic [15:0] c;
    logic b;
    c = '0;
    @(negedge clk); sd1 = 1'b0; s = cyc + 1;
    for (int k = 0; k < len; k++) begin
      for (int i = 7; i >= 0; i--) begin
        b = blk_bytes[base+k][i];
        @(negedge clk); sd1 = b;
        c = crc_step(c, b);
      end
    end
    for (int i = 0; i < 16; i++) begin @(negedge clk); sd1 = c[15-i]; end
    @(negedge clk); sd1 = 1'b1;
    @(negedge clk); sd1 = 1'b1;
  endtask

  initial begin
    int t, s, s2, a, d0, busy_low;
    blk_bytes[0] = 8'h12; blk_bytes[1] = 8'h34; blk_bytes[2] = 8'h56; blk_bytes[3] = 8'h78;
    blk_bytes[4] = 8'h9A; blk_bytes[5] = 8'hBC; blk_bytes[6] = 8'hDE; blk_bytes[7] = 8'hF0;
    blk_bytes[8] = 8'hA5;

    repeat (3) @(negedge clk);
    chk("rst_out4", int'({data4, vld4, sop4, eop4, busy4, done4, status4}), 0);
    chk("rst_out1", int'({data1, vld1, sop1, eop1, busy1, done1, status1}), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic 4-byte block
    exp4(8'h12, 1, 0); exp4(8'h34, 0, 0); exp4(8'h56, 0, 0); exp4(8'h78, 0, 1);
    d0 = done_n4;
    start_x4(4, 1, t);
    chk("t1_busy_at_t+1", int'(busy4), 1);
    block4(0, 4, 4, -1, 0, s);
    repeat (6) @(negedge clk);
    chk("t1_done_cyc", last_done4, s + 26);
    chk("t1_done_n", done_n4 - d0, 1);
    chk("t1_status", int'(status4), 8'h00);
    chk("t1_q", q4.size(), 0);
    chk("t1_idle_busy", int'(busy4), 0);

    // CRC bit flipped on DAT2
    exp4(8'h12, 1, 0); exp4(8'h34, 0, 0); exp4(8'h56, 0, 0); exp4(8'h78, 0, 1);
    start_x4(4, 1, t);
    block4(0, 4, 4, 2, 0, s);
    repeat (6) @(negedge clk);
    chk("t2_crc_status", int'(status4), 8'h04);

    // DAT0 end bit low
    exp4(8'h12, 1, 0); exp4(8'h34, 0, 0); exp4(8'h56, 0, 0); exp4(8'h78, 0, 1);
    start_x4(4, 1, t);
    block4(0, 4, 4, -1, 1, s);
    repeat (6) @(negedge clk);
    chk("t2_end_status", int'(status4), 8'h10);

    // Two blocks of two bytes with an idle gap
    exp4(8'h12, 1, 0); exp4(8'h34, 0, 0); exp4(8'h56, 0, 0); exp4(8'h78, 0, 1);
    d0 = done_n4;
    start_x4(2, 2, t);
    block4(0, 2, 2, -1, 0, s);
    busy_low = 0;
    if (!busy4) busy_low++;
    repeat (9) begin @(negedge clk); if (!busy4) busy_low++; end
    block4(2, 2, 2, -1, 0, s2);
    repeat (6) @(negedge clk);
    chk("t3_gap_busy_low", busy_low, 0);
    chk("t3_done_cyc", last_done4, s2 + 22);
    chk("t3_done_n", done_n4 - d0, 1);
    chk("t3_status", int'(status4), 8'h00);
    chk("t3_q", q4.size(), 0);

    // Timeout with lines held high
    start_x4(4, 1, t);
    repeat (30) @(negedge clk);
    chk("t4_done_cyc", last_done4, t + 21);
    chk("t4_status", int'(status4), 8'h40);

    // Abort after two bytes
    exp4(8'h12, 1, 0); exp4(8'h34, 0, 0); exp4(8'h00, 0, 1);
    start_x4(4, 1, t);
    block4(0, 4, 2, -1, 0, s);
    @(negedge clk); abort4 = 1'b1; sd4 = 4'hF; a = cyc + 1;
    @(negedge clk); abort4 = 1'b0;
    repeat (6) @(negedge clk);
    chk("t5_done_cyc", last_done4, a + 1);
    chk("t5_status", int'(status4), 8'h20);
    chk("t5_q", q4.size(), 0);

    // Overrun with the stream stalled
    @(negedge clk); rdy4 = 1'b0;
    exp4(8'h12, 1, 0); exp4(8'h34, 0, 0); exp4(8'h56, 0, 0); exp4(8'h78, 0, 0);
    start_x4(8, 1, t);
    block4(0, 8, 8, -1, 0, s);
    repeat (4) @(negedge clk);
    chk("t6_status", int'(status4), 8'h80);
    chk("t6_head", int'({vld4, sop4, data4}), int'({1'b1, 1'b1, 8'h12}));
    rdy4 = 1'b1;
    repeat (10) @(negedge clk);
    chk("t6_drained", q4.size(), 0);
    chk("t6_vld_after", int'(vld4), 0);

    // 1-line bus, single byte
    q1.push_back({1'b1, 1'b1, 8'hA5});
    start_x1(1, 1, t);
    block1(8, 1, s);
    repeat (6) @(negedge clk);
    chk("t7_done_cyc", last_done1, s + 26);
    chk("t7_status", int'(status1), 8'h00);
    chk("t7_q", q1.size(), 0);

    // Reset pulsed mid-DATA
    d0 = done_n1;
    start_x1(1, 1, t);
    @(negedge clk); sd1 = 1'b0;
    @(negedge clk); sd1 = 1'b1;
    @(negedge clk); sd1 = 1'b0;
    @(negedge clk); sd1 = 1'b1;
    #2;
    chk("t8_busy_pre", int'(busy1), 1);
    rst = 1'b1;
    #1;
    chk("t8_rst_out1", int'({data1, vld1, sop1, eop1, busy1, done1, status1}), 0);
    @(negedge clk); rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("t8_no_done", done_n1 - d0, 0);
    chk("t8_idle", int'({vld1, busy1, status1}), 0);

    chk("final_q4", q4.size(), 0);
    chk("final_q1", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
